mybusmatrix5x7_outstage_rr: RTL
===============================

// Module: mybusmatrix5x7_outstage_rr
// PURPOSE
// - Output stage for one slave-side port of the 5x7 AHB matrix; the responder end of each input-port decoder.
// - Takes per-input-port select/address/control, arbitrates round-robin and drives one AHB slave.
// - Tracks which input owns the data phase and returns active/ready/resp/rdata to the decoders.
// PARAMETERS
// - NUM_IN  5   number of input ports (decoders) connected
// - AW      32  address width
// - DW      32  read/write data width
// - UW      32  HRUSER width
// PORTS
// - HCLK        in   1         AHB clock
// - HRESETn     in   1         async active-low reset
// - sel_op      in   NUM_IN    per-input select from decoder (sel_decN)
// - addr_op     in   NUM_IN*AW per-input HADDR (input i at [i*AW +: AW])
// - trans_op    in   NUM_IN*2  per-input HTRANS
// - write_op    in   NUM_IN    per-input HWRITE
// - size_op     in   NUM_IN*3  per-input HSIZE
// - burst_op    in   NUM_IN*3  per-input HBURST
// - prot_op     in   NUM_IN*4  per-input HPROT
// - lock_op     in   NUM_IN    per-input HMASTLOCK
// - wdata_op    in   NUM_IN*DW per-input HWDATA (data phase)
// - active_op   out  NUM_IN    one-hot grant; feeds decoder active_decN
// - HSELM HADDRM HTRANSM HWRITEM HSIZEM HBURSTM HPROTM HMASTLOCKM HWDATAM  out  1/AW/2/1/3/3/4/1/DW  slave bus
// - HREADYMUXM  out  1         HREADY to slave
// - HREADYOUTM  in   1         slave HREADYOUT
// - HRESPM      in   2         slave HRESP
// - HRDATAM     in   DW        slave HRDATA
// - HRUSERM     in   UW        slave HRUSER
// - readyout_op out  1         to decoders (readyout_decN)
// - resp_op     out  2         to decoders (resp_decN)
// - rdata_op    out  DW        to decoders (rdata_decN)
// - ruser_op    out  UW        to decoders (ruser_decN)
// BEHAVIOUR
// - Clock HCLK; reset HRESETn asynchronous, active-low. Reset: last_owner=NUM_IN-1, hold=0, data_valid=0.
// - Reset outputs: HSELM=0, HTRANSM=IDLE, active_op=0, HREADYMUXM=1, readyout_op=1, resp_op=OKAY; addr mux points at port 0.
// - req[i] = sel_op[i] & trans_op[i][1] (NONSEQ/SEQ).
// - Arbitration combinational, zero latency: hold=1 -> owner=last_owner; else first req scanning from (last_owner+1) mod NUM_IN, wrapping.
// - No req and no hold -> owner=last_owner, HSELM=0, HTRANSM=IDLE, active_op=0 (parked).
// - Granted: HSELM=sel_op[owner]; address/control muxed from owner; active_op = onehot(owner) & HSELM.
// - State updates only when HREADYOUTM=1 (address phase completes): last_owner<=owner; hold<=1 if owner trans=SEQ/BUSY follows
//   (burst continuing: burst_op!=SINGLE and next beat expected) or lock_op[owner]=1; hold<=0 on owner trans IDLE/NONSEQ with lock=0.
// - Data phase: on HREADYOUTM=1 data_valid<=HSELM&trans[1], data_port<=owner. HWDATAM = wdata_op[data_port].
// - HREADYMUXM = data_valid ? HREADYOUTM : 1. readyout_op = same. resp_op = data_valid ? HRESPM : OKAY.
// - rdata_op=HRDATAM, ruser_op=HRUSERM passed through (decoder muxes by its data_out_port).
// - Wait states (HREADYOUTM=0): all address/control/grant outputs held stable; no re-arbitration.
// - ERROR: two-cycle HRESPM=ERROR forwarded unchanged; owner IDLE during 2nd cycle releases hold.
// - Simultaneous new req and burst end: released owner has lowest priority next round.
// - Reset mid-transfer: all registers cleared immediately; outstanding transfer discarded.
// CONFIGURATION
// - MYBUSMATRIX5X7_FIXED_PRIORITY_EN defined: arbitration picks lowest-index req (hold rules unchanged).
// - Undefined: round-robin as above.
// TESTING
// - Reset with all inputs active -> HSELM=0, HTRANSM=00, active_op=0, readyout_op=1, resp_op=00 until release.
// - Port2 NONSEQ write 0x0000_1000, slave ready -> same cycle HSELM=1, HADDRM=0x1000, active_op=5'b00100; next HWDATAM=wdata_op[2].
// - Ports 0,1,3 each single NONSEQ every cycle, HREADYOUTM=1 -> grant sequence 0,1,3,0,1,3.
// - Port1 INCR4 while port0 requests, 2 wait states on beat 2 -> outputs stable in waits; port0 granted only after beat 4 address.
// - Slave ERROR: HRESPM=01 with HREADYOUTM 0 then 1 -> resp_op=01 both cycles, readyout_op 0 then 1; IDLE from owner clears hold.
// - With MYBUSMATRIX5X7_FIXED_PRIORITY_EN, ports 3 and 1 requesting continuously -> port1 every grant; without macro 1,3 alternate.

Source files
------------

// File: rtl/mybusmatrix5x7_outstage_rr.sv
// mybusmatrix5x7_outstage_rr: slave-side output stage of the 5x7 AHB matrix.
// Arbitrates round-robin between input ports, or lowest-index-first when
// MYBUSMATRIX5X7_FIXED_PRIORITY_EN is defined, and routes the data phase back.
module mybusmatrix5x7_outstage_rr #(
    parameter int NUM_IN = 5,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int UW     = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_IN-1:0]    sel_op,
    input  logic [NUM_IN*AW-1:0] addr_op,
    input  logic [NUM_IN*2-1:0]  trans_op,
    input  logic [NUM_IN-1:0]    write_op,
    input  logic [NUM_IN*3-1:0]  size_op,
    input  logic [NUM_IN*3-1:0]  burst_op,
    input  logic [NUM_IN*4-1:0]  prot_op,
    input  logic [NUM_IN-1:0]    lock_op,
    input  logic [NUM_IN*DW-1:0] wdata_op,
    output logic [NUM_IN-1:0]    active_op,
    output logic                 HSELM,
    output logic [AW-1:0]        HADDRM,
    output logic [1:0]           HTRANSM,
    output logic                 HWRITEM,
    output logic [2:0]           HSIZEM,
    output logic [2:0]           HBURSTM,
    output logic [3:0]           HPROTM,
    output logic                 HMASTLOCKM,
    output logic [DW-1:0]        HWDATAM,
    output logic                 HREADYMUXM,
    input  logic                 HREADYOUTM,
    input  logic [1:0]           HRESPM,
    input  logic [DW-1:0]        HRDATAM,
    input  logic [UW-1:0]        HRUSERM,
    output logic                 readyout_op,
    output logic [1:0]           resp_op,
    output logic [DW-1:0]        rdata_op,
    output logic [UW-1:0]        ruser_op
);
    localparam int PW = $clog2(NUM_IN);

    logic [NUM_IN-1:0] w_req;
    logic [PW-1:0]     w_arb, w_owner, w_sel;
    logic              w_gnt, w_hold_nx;
    logic [1:0]        w_tr;
    logic [3:0]        w_len, w_rem;
    logic [PW-1:0]     r_last, r_howner, r_dport;
    logic              r_hold, r_hvalid, r_hgnt, r_dvalid;
    logic [3:0]        r_cnt;

    // A port requests when selected with an active (NONSEQ/SEQ) transfer
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_IN; i++) w_req[i] = sel_op[i] & trans_op[2*i+1];
    end

`ifdef MYBUSMATRIX5X7_FIXED_PRIORITY_EN
    // Lowest-index requester wins; parks on the last owner when idle
    always_comb begin
        w_arb = r_last;
        for (int k = NUM_IN - 1; k >= 0; k--) if (w_req[k]) w_arb = PW'(k);
    end
`else
    logic [PW:0] w_idx;
    // Scan from the port after the last owner so the last owner ranks lowest
    always_comb begin
        w_arb = r_last;
        w_idx = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            w_idx = {1'b0, r_last} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(NUM_IN)) w_idx = w_idx - (PW+1)'(NUM_IN);
            if (w_req[w_idx[PW-1:0]]) w_arb = w_idx[PW-1:0];
        end
    end
`endif

    // Pick the owner (frozen during wait states) and mux its address/control
    always_comb begin
        w_owner    = r_hvalid ? r_howner : (r_hold ? r_last : w_arb);
        w_gnt      = HRESETn & (r_hvalid ? r_hgnt : (r_hold | (|w_req)));
        w_sel      = w_gnt ? w_owner : '0;
        HSELM      = w_gnt & sel_op[w_sel];
        w_tr       = HSELM ? trans_op[int'(w_sel)*2 +: 2] : 2'b00;
        HTRANSM    = w_tr;
        HADDRM     = addr_op[int'(w_sel)*AW +: AW];
        HWRITEM    = write_op[w_sel];
        HSIZEM     = size_op[int'(w_sel)*3 +: 3];
        HBURSTM    = burst_op[int'(w_sel)*3 +: 3];
        HPROTM     = prot_op[int'(w_sel)*4 +: 4];
        HMASTLOCKM = lock_op[w_sel];
        active_op  = HSELM ? {{(NUM_IN-1){1'b0}}, 1'b1} << w_owner : '0;
    end

    // Beats remaining in a fixed-length burst decide whether the grant is held
    always_comb begin
        w_len     = HBURSTM[2:1] == 2'b01 ? 4'd3 : HBURSTM[2:1] == 2'b10 ? 4'd7 :
                    HBURSTM[2:1] == 2'b11 ? 4'd15 : 4'd0;
        w_rem     = w_tr == 2'b10 ? w_len : r_cnt - 4'd1;
        w_hold_nx = w_gnt & (HMASTLOCKM | (w_tr[1] ? (HBURSTM == 3'b001) | (|w_rem) :
                    (w_tr == 2'b01) & r_hold));
    end

    // Arbitration and data-phase state advance only when the address phase completes
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_last   <= PW'(NUM_IN - 1);
            r_hold   <= 1'b0;
            r_hvalid <= 1'b0;
            r_howner <= '0;
            r_hgnt   <= 1'b0;
            r_dvalid <= 1'b0;
            r_dport  <= '0;
            r_cnt    <= '0;
        end else begin
            r_hvalid <= ~HREADYOUTM;
            r_howner <= w_owner;
            r_hgnt   <= w_gnt;
            if (HREADYOUTM) begin
                r_last   <= w_owner;
                r_hold   <= w_hold_nx;
                r_dvalid <= HSELM & w_tr[1];
                r_dport  <= w_owner;
                if (HSELM & w_tr[1]) r_cnt <= w_rem;
            end
        end
    end

    // Data-phase return path; idle data phase reports ready/OKAY
    always_comb begin
        HWDATAM     = wdata_op[int'(r_dport)*DW +: DW];
        HREADYMUXM  = r_dvalid ? HREADYOUTM : 1'b1;
        readyout_op = HREADYMUXM;
        resp_op     = r_dvalid ? HRESPM : 2'b00;
        rdata_op    = HRDATAM;
        ruser_op    = HRUSERM;
    end
endmodule
